// File: rtl/pdh_frame_capture.sv
// Frame capture responder: decimates the sample stream into fixed-length AXI4-Stream frames for the PS DMA.
// Optional macro FRAME_HEADER_EN prefixes each frame with a {16'hA5A5, frame_id, dec} header beat.
module pdh_frame_capture #(
  parameter int DATA_WIDTH = 64,
  parameter int DEC_WIDTH  = 26,
  parameter int FRAME_LEN  = 16384,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DEC_WIDTH-1:0]  decimation_code_i,
  output logic                  engaged_o,
  output logic                  finished_o,
  output logic                  overflow_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

`ifdef FRAME_HEADER_EN
  localparam int HDR_BEATS = 1;
`else
  localparam int HDR_BEATS = 0;
`endif
  localparam int TOTAL = FRAME_LEN + HDR_BEATS;
  localparam int EW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(FRAME_LEN + 1);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [EW-1:0] TOTAL_E = EW'(TOTAL);
  localparam logic [EW-1:0] LAST_E  = EW'(TOTAL - 1);
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME_LEN);
  localparam logic [BW-1:0] BUF_MAX = BW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_PAD     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEC_WIDTH-1:0]  dec_q, dec_d, dec_cnt_q, dec_cnt_d, dec_eff_s;
  logic [CW-1:0]         cap_cnt_q, cap_cnt_d;
  logic [EW-1:0]         emit_cnt_q, emit_cnt_d, emit_base_s;
  logic                  overflow_q, overflow_d, engaged_q, engaged_d, finished_q, finished_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d, push_data_s;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]         buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  start_s, pop_s, full_s, cap_evt_s, accept_s, push_s, fill_s;
  logic                  buf_rd_s, buf_wr_s;
`ifdef FRAME_HEADER_EN
  logic [21:0]           frame_id_q, frame_id_d;
`endif

  // Next-state, buffer steering and output-register load
  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    dec_cnt_d   = dec_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    overflow_d  = overflow_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    buf_rd_s    = 1'b0;
    buf_wr_s    = 1'b0;
    push_data_s = data_i;

    dec_eff_s   = (decimation_code_i == '0) ? DEC_WIDTH'(1) : decimation_code_i;
    pop_s       = tvalid_q & m_axis_tready;
    full_s      = tvalid_q & (buf_cnt_q == BUF_MAX);
    start_s     = (state_q == S_IDLE) & enable_i;
    cap_evt_s   = (state_q == S_CAPTURE) & enable_i & (cap_cnt_q != FRAME_C) & (dec_cnt_q == '0);
    accept_s    = cap_evt_s & (~full_s | pop_s);
    fill_s      = (state_q == S_PAD) | ((state_q == S_CAPTURE) & (cap_cnt_q == FRAME_C));
    emit_base_s = start_s ? '0 : (emit_cnt_q + EW'(pop_s));
    push_s      = accept_s;
`ifdef FRAME_HEADER_EN
    if (start_s) begin
      push_s      = 1'b1;
      push_data_s = DATA_WIDTH'({16'hA5A5, frame_id_q, dec_eff_s});
    end else begin
      push_data_s = data_i;
    end
`endif

    // The output register is the head slot of the buffer; a free slot takes the oldest entry,
    // else a bypassed push, else a zero pad beat once no more samples can arrive.
    if (~tvalid_q | pop_s) begin
      tlast_d = (emit_base_s == LAST_E);
      if (buf_cnt_q != '0) begin
        tvalid_d = 1'b1;
        tdata_d  = mem_q[rd_ptr_q];
        buf_rd_s = 1'b1;
        buf_wr_s = push_s;
      end else if (push_s) begin
        tvalid_d = 1'b1;
        tdata_d  = push_data_s;
      end else if (fill_s & (emit_base_s != TOTAL_E)) begin
        tvalid_d = 1'b1;
        tdata_d  = '0;
      end else begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end else begin
      buf_wr_s = push_s;
    end

    wr_ptr_d   = wr_ptr_q + PW'(buf_wr_s);
    rd_ptr_d   = rd_ptr_q + PW'(buf_rd_s);
    buf_cnt_d  = buf_cnt_q + BW'(buf_wr_s) - BW'(buf_rd_s);
    emit_cnt_d = emit_base_s;

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d    = S_CAPTURE;
          dec_d      = dec_eff_s;
          dec_cnt_d  = '0;
          cap_cnt_d  = '0;
          overflow_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (cap_evt_s) begin
          cap_cnt_d  = cap_cnt_q + CW'(1);
          overflow_d = overflow_q | ~accept_s;
        end else begin
          cap_cnt_d = cap_cnt_q;
        end
        dec_cnt_d = (dec_cnt_q == dec_q - DEC_WIDTH'(1)) ? '0 : dec_cnt_q + DEC_WIDTH'(1);
        if (emit_cnt_q == TOTAL_E) begin
          state_d = S_DONE;
        end else if (!enable_i) begin
          state_d = S_PAD;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_PAD: begin
        if (emit_cnt_q == TOTAL_E) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PAD;
        end
      end
      S_DONE: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    engaged_d  = (state_d == S_CAPTURE) | (state_d == S_PAD);
    finished_d = (state_d == S_DONE);
`ifdef FRAME_HEADER_EN
    frame_id_d = frame_id_q + 22'((state_d == S_DONE) & (state_q != S_DONE));
`endif
  end

  // Control, counters and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dec_q      <= DEC_WIDTH'(1);
      dec_cnt_q  <= '0;
      cap_cnt_q  <= '0;
      emit_cnt_q <= '0;
      overflow_q <= 1'b0;
      engaged_q  <= 1'b0;
      finished_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      buf_cnt_q  <= '0;
`ifdef FRAME_HEADER_EN
      frame_id_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dec_q      <= dec_d;
      dec_cnt_q  <= dec_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      overflow_q <= overflow_d;
      engaged_q  <= engaged_d;
      finished_q <= finished_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_cnt_q  <= buf_cnt_d;
`ifdef FRAME_HEADER_EN
      frame_id_q <= frame_id_d;
`endif
    end
  end

  // Buffer storage; flushed by pointer reset, contents need no reset
  always_ff @(posedge clk) begin
    if (buf_wr_s) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

  assign engaged_o     = engaged_q;
  assign finished_o    = finished_q;
  assign overflow_o    = overflow_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_pdh_frame_capture.sv
// Scoreboard bench for pdh_frame_capture: driver predicts each frame's beats, monitor checks transfers.
module tb_pdh_frame_capture;
  localparam int FL = 8;
  localparam int FD = 4;
`ifdef FRAME_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL = FL + HDR;

  logic        clk = 1'b0;
  logic        rst, enable_i, m_axis_tready;
  logic [63:0] data_i, m_axis_tdata;
  logic [25:0] decimation_code_i;
  logic        engaged_o, finished_o, overflow_o, m_axis_tvalid, m_axis_tlast;

  pdh_frame_capture #(.DATA_WIDTH(64), .DEC_WIDTH(26), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .data_i(data_i),
    .decimation_code_i(decimation_code_i), .engaged_o(engaged_o), .finished_o(finished_o),
    .overflow_o(overflow_o), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] data; logic last; } beat_t;
  beat_t       exp_q[$];
  beat_t       mon_b;
  int          total = 0, bad = 0, exp_idx = 0, frame_id_m = 0;
  bit          mon_en = 1'b1, prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Expected beat list of the current frame; tlast belongs to beat TOTAL-1
  task automatic push_exp(input logic [63:0] d);
    beat_t b;
    b.data = d;
    b.last = (exp_idx == TOTAL - 1);
    exp_q.push_back(b);
    exp_idx++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %h expected no beat", m_axis_tdata);
        end else begin
          mon_b = exp_q.pop_front();
          check("tdata", m_axis_tdata, mon_b.data);
          check("tlast", 64'(m_axis_tlast), 64'(mon_b.last));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // mode 0: tready high while capturing; mode 1: tready low for the first 40 cycles.
  // abort_n: edge index at which enable_i is dropped (-1 = never).
  task automatic run_frame(input logic [25:0] code, input int mode, input int abort_n);
    int d, k, n, kept, lim, budget;
    bit cap_done;
    logic [63:0] s;
    d        = (code == 26'd0) ? 1 : int'(code);
    lim      = (mode == 1) ? (FD - HDR) : FL;
    exp_idx  = 0;
    k        = 0;
    n        = 0;
    kept     = 0;
    cap_done = 1'b0;
    enable_i = 1'b1;
    decimation_code_i = code;
    m_axis_tready = (mode == 1) ? 1'b0 : 1'b1;
`ifdef FRAME_HEADER_EN
    push_exp({16'hA5A5, 22'(frame_id_m), 26'(d)});
`endif
    while (!cap_done) begin
      s      = {$urandom, $urandom};
      data_i = s;
      if (n >= 1) decimation_code_i = 26'($urandom);
      if (n == abort_n) enable_i = 1'b0;
      if (enable_i && n >= 1 && ((n - 1) % d) == 0) begin
        k++;
        if (kept < lim) begin
          push_exp(s);
          kept++;
        end
      end
      if (k == FL || !enable_i) begin
        cap_done = 1'b1;
        while (exp_idx < TOTAL) push_exp(64'd0);
      end
      step();
      n++;
    end
    budget = 0;
    while (!finished_o && budget < 3000) begin
      data_i = {$urandom, $urandom};
      if (mode == 1 && n < 40) m_axis_tready = 1'b0;
      else m_axis_tready = 1'($urandom_range(0, 1));
      step();
      n++;
      budget++;
    end
    check("finished", 64'(finished_o), 64'd1);
    check("engaged_done", 64'(engaged_o), 64'd0);
    check("overflow", 64'(overflow_o), (k > kept) ? 64'd1 : 64'd0);
    check("beats_left", 64'(exp_q.size()), 64'd0);
    enable_i = 1'b0;
    step();
    check("finished_clear", 64'(finished_o), 64'd0);
    step();
    exp_q.delete();
    frame_id_m++;
  endtask

  task automatic rst_mid_frame();
    mon_en = 1'b0;
    enable_i = 1'b1;
    decimation_code_i = 26'd1;
    m_axis_tready = 1'b0;
    repeat (5) begin
      data_i = {$urandom, $urandom};
      step();
    end
    check("pre_rst_valid", 64'(m_axis_tvalid), 64'd1);
    check("pre_rst_engaged", 64'(engaged_o), 64'd1);
    rst = 1'b1;
    enable_i = 1'b0;
    step();
    check("rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("rst_engaged", 64'(engaged_o), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();
    check("post_rst_empty", 64'(m_axis_tvalid), 64'd0);
    exp_q.delete();
    frame_id_m = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    int mode, abort_n;
    logic [25:0] code;
    rst = 1'b1;
    enable_i = 1'b0;
    data_i = 64'd0;
    decimation_code_i = 26'd0;
    m_axis_tready = 1'b0;
    repeat (3) step();
    check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("reset_tlast", 64'(m_axis_tlast), 64'd0);
    check("reset_tdata", m_axis_tdata, 64'd0);
    check("reset_engaged", 64'(engaged_o), 64'd0);
    check("reset_finished", 64'(finished_o), 64'd0);
    check("reset_overflow", 64'(overflow_o), 64'd0);
    rst = 1'b0;
    run_frame(26'd1, 0, -1);
    run_frame(26'd4, 0, -1);
    run_frame(26'd0, 0, -1);
    run_frame(26'd1, 1, -1);
    run_frame(26'd1, 0, 4);
    for (int i = 0; i < 8; i++) begin
      mode    = int'($urandom_range(0, 1));
      code    = (mode == 1) ? 26'($urandom_range(0, 1)) : 26'($urandom_range(0, 5));
      abort_n = (mode == 0 && ($urandom % 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      run_frame(code, mode, abort_n);
    end
    rst_mid_frame();
    run_frame(26'd2, 0, -1);
    run_frame(26'd0, 1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
